instr_packer: RTL

INSTR_PACKER -- requirements
Module: instr_packer

---
 rtl/instr_packer_pkg.sv | 60 ++++++
 rtl/instr_packer_fifo.sv | 63 ++++++
 rtl/instr_packer.sv | 96 +++++++++
 3 files changed

// File: rtl/instr_packer_pkg.sv
// Shared definitions for the instruction packer: format codes, the default
// base address, instruction field positions and the word packing helper.
package instr_packer_pkg;

    typedef enum logic [1:0] {
        FMT_R   = 2'b00,
        FMT_I   = 2'b01,
        FMT_J   = 2'b10,
        FMT_BAD = 2'b11
    } fmt_e;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_3000;
    localparam logic [31:0] ADDR_STEP         = 32'd4;

    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned RS_MSB    = 25;
    localparam int unsigned RT_MSB    = 20;
    localparam int unsigned RD_MSB    = 15;
    localparam int unsigned SHAMT_MSB = 10;
    localparam int unsigned IMM26_MSB = 25;

    // The immediate field of an I-type word occupies the rd/shamt/func bits.
    function automatic logic [31:0] pack_word(
        input fmt_e        f,
        input logic [5:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [5:0]  func,
        input logic [15:0] imm16,
        input logic [25:0] imm26
    );
        logic [31:0] w;
        w = '0;
        w[OP_MSB -: 6] = op;
        case (f)
            FMT_R: begin
                w[RS_MSB -: 5]    = rs;
                w[RT_MSB -: 5]    = rt;
                w[RD_MSB -: 5]    = rd;
                w[SHAMT_MSB -: 5] = shamt;
                w[5:0]            = func;
            end
            FMT_I: begin
                w[RS_MSB -: 5]  = rs;
                w[RT_MSB -: 5]  = rt;
                w[RD_MSB -: 16] = imm16;
            end
            FMT_J: begin
                w[IMM26_MSB -: 26] = imm26;
            end
            default: begin
                w = '0;
            end
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_packer_fifo.sv
// Registered-storage FIFO holding packed {instruction, address} entries.
// Head output is zero while empty so the block's outputs read 0 after reset.
module instr_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_q;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/instr_packer.sv
// Packs decoded instruction fields into 32-bit words, tags each with a
// sequential byte address and queues {word, addr} for a downstream consumer.
module instr_packer
    import instr_packer_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             fmt,
    input  logic [5:0]             op,
    input  logic [4:0]             rs,
    input  logic [4:0]             rt,
    input  logic [4:0]             rd,
    input  logic [4:0]             shamt,
    input  logic [5:0]             func,
    input  logic [15:0]            imm16,
    input  logic [25:0]            imm26,
    input  logic                   clr_addr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instr,
    output logic [31:0]            out_addr,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err_fmt
);

    fmt_e        fmt_code;
    logic        accept;
    logic        push;
    logic        bad_accept;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] addr_cnt;
    logic [31:0] entry_addr;
    logic [31:0] word;
    logic [63:0] fifo_din;
    logic [63:0] fifo_dout;

    assign fmt_code   = fmt_e'(fmt);
    assign in_ready   = !fifo_full;
    assign out_valid  = !fifo_empty;
    assign accept     = in_valid && in_ready;
    assign push       = accept && (fmt_code != FMT_BAD);
    assign bad_accept = accept && (fmt_code == FMT_BAD);
    assign pop        = out_valid && out_ready;

    // A clear coinciding with a push retargets that push to BASE_ADDR.
    assign entry_addr = clr_addr ? BASE_ADDR : addr_cnt;

    always_comb begin
        word = pack_word(fmt_code, op, rs, rt, rd, shamt, func, imm16, imm26);
    end

    assign fifo_din  = {word, entry_addr};
    assign out_instr = fifo_dout[63:32];
    assign out_addr  = fifo_dout[31:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_cnt <= BASE_ADDR;
        end else if (push) begin
            addr_cnt <= entry_addr + ADDR_STEP;
        end else if (clr_addr) begin
            addr_cnt <= BASE_ADDR;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_fmt <= 1'b0;
        end else if (bad_accept) begin
            err_fmt <= 1'b1;
        end
    end

    instr_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
